light_dance_demux: RTL and testbench



---
 rtl/light_dance_pkg.sv | 23 ++
 rtl/ld_deserializer.sv | 43 ++++
 rtl/light_dance_demux.sv | 116 +++++++++++
 tb/tb_light_dance_demux.sv | 263 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/light_dance_pkg.sv
// Shared constants for the light-dance serial-to-bank demux.
// Holds the FSM state encoding, the bank select polarity (matching the 2:1
// utils mux: 1 = bank A, 0 = bank B), the default bank width and a helper
// for the bit-counter width.
package light_dance_pkg;

  localparam int unsigned LD_WIDTH = 8;

  typedef logic [1:0] ld_state_t;

  localparam ld_state_t LD_IDLE   = 2'd0;
  localparam ld_state_t LD_SHIFT  = 2'd1;
  localparam ld_state_t LD_COMMIT = 2'd2;

  localparam logic LD_BANK_A = 1'b1;
  localparam logic LD_BANK_B = 1'b0;

  // Counter must be able to hold the value WIDTH.
  function automatic int unsigned ld_cnt_width(input int unsigned width);
    return $clog2(width + 1);
  endfunction

endpackage

// File: rtl/ld_deserializer.sv
// MSB-first serial-to-parallel shift register with a bit counter.
// Ports:
//   clk, reset  : clock, synchronous active-high reset
//   shift_en    : accept din this cycle
//   first_bit   : the accepted bit starts a new frame (counter reloads to 1)
//   din         : serial data bit
//   data        : assembled frame (first accepted bit ends up in data[WIDTH-1])
//   done_c      : combinational, this accepted bit completes the frame
module ld_deserializer
  import light_dance_pkg::*;
#(
  parameter int unsigned WIDTH = LD_WIDTH
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             shift_en,
  input  logic             first_bit,
  input  logic             din,
  output logic [WIDTH-1:0] data,
  output logic             done_c
);

  localparam int unsigned CNT_W = ld_cnt_width(WIDTH);

  logic [CNT_W-1:0] cnt;

  // Shift register and bit counter.
  always_ff @(posedge clk) begin
    if (reset) begin
      data <= '0;
      cnt  <= '0;
    end else if (shift_en) begin
      data <= {data[WIDTH-2:0], din};
      cnt  <= first_bit ? CNT_W'(1) : cnt + CNT_W'(1);
    end
  end

  // Frame completes on the transfer that sees WIDTH-1 bits already held.
  always_comb begin
    done_c = shift_en && !first_bit && (cnt == CNT_W'(WIDTH - 1));
  end

endmodule

// File: rtl/light_dance_demux.sv
// Serial pattern demux: assembles WIDTH-bit frames from a valid/ready serial
// stream and commits each frame to LED bank A or B chosen by the sel bit
// seen with the frame's first bit.
// Ports:
//   clk, reset      : clock, synchronous active-high reset
//   din, din_valid  : serial bit (MSB first) and its valid
//   din_ready       : ready, decoded from state only (low during COMMIT)
//   sel             : destination bank, 1 = A, 0 = B, sampled on first bit
//   leds_a, leds_b  : registered bank patterns
//   upd_a, upd_b    : one-cycle pulse with each new bank value
//   busy            : frame partially received or being committed
module light_dance_demux
  import light_dance_pkg::*;
#(
  parameter int unsigned WIDTH = LD_WIDTH
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             din,
  input  logic             din_valid,
  output logic             din_ready,
  input  logic             sel,
  output logic [WIDTH-1:0] leds_a,
  output logic [WIDTH-1:0] leds_b,
  output logic             upd_a,
  output logic             upd_b,
  output logic             busy
);

  ld_state_t        state_q;
  ld_state_t        state_d;
  logic             dest_q;
  logic             xfer;
  logic             first_bit;
  logic             commit;
  logic             done_c;
  logic [WIDTH-1:0] frame;

  ld_deserializer #(.WIDTH(WIDTH)) u_deser (
    .clk       (clk),
    .reset     (reset),
    .shift_en  (xfer),
    .first_bit (first_bit),
    .din       (din),
    .data      (frame),
    .done_c    (done_c)
  );

  // State register.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= LD_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    case (state_q)
      LD_IDLE:   if (xfer)   state_d = LD_SHIFT;
      LD_SHIFT:  if (done_c) state_d = LD_COMMIT;
      LD_COMMIT: state_d = LD_IDLE;
      default:   state_d = LD_IDLE;
    endcase
  end

  // State-decoded controls; din_ready has no path from din_valid.
  always_comb begin
    din_ready = 1'b0;
    first_bit = 1'b0;
    commit    = 1'b0;
    case (state_q)
      LD_IDLE: begin
        din_ready = 1'b1;
        first_bit = 1'b1;
      end
      LD_SHIFT:  din_ready = 1'b1;
      LD_COMMIT: commit = 1'b1;
      default: begin
        din_ready = 1'b0;
      end
    endcase
    xfer = din_valid && din_ready;
  end

  // Destination latch, bank registers, update pulses and busy flag.
  always_ff @(posedge clk) begin
    if (reset) begin
      dest_q <= LD_BANK_B;
      leds_a <= '0;
      leds_b <= '0;
      upd_a  <= 1'b0;
      upd_b  <= 1'b0;
      busy   <= 1'b0;
    end else begin
      upd_a <= 1'b0;
      upd_b <= 1'b0;
      busy  <= (state_d != LD_IDLE);
      if (xfer && first_bit) begin
        dest_q <= sel;
      end
      if (commit) begin
        if (dest_q == LD_BANK_A) begin
          leds_a <= frame;
          upd_a  <= 1'b1;
        end else begin
          leds_b <= frame;
          upd_b  <= 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_light_dance_demux.sv
module tb_light_dance_demux;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       reset;
  logic       in_v [2];
  logic       in_d [2];
  logic       in_s [2];

  logic       rdy8, ua8, ub8, busy8;
  logic [7:0] la8, lb8;
  logic       rdy4, ua4, ub4, busy4;
  logic [3:0] la4, lb4;

  light_dance_demux #(.WIDTH(8)) dut8 (
    .clk(clk), .reset(reset), .din(in_d[0]), .din_valid(in_v[0]),
    .din_ready(rdy8), .sel(in_s[0]), .leds_a(la8), .leds_b(lb8),
    .upd_a(ua8), .upd_b(ub8), .busy(busy8)
  );

  light_dance_demux #(.WIDTH(4)) dut4 (
    .clk(clk), .reset(reset), .din(in_d[1]), .din_valid(in_v[1]),
    .din_ready(rdy4), .sel(in_s[1]), .leds_a(la4), .leds_b(lb4),
    .upd_a(ua4), .upd_b(ub4), .busy(busy4)
  );

  int W [2] = '{8, 4};

  int vectors = 0;
  int fails   = 0;
  int cyc     = 0;
  bit chk_en  = 1'b0;

  int ua_cnt [2];
  int ub_cnt [2];
  int low_cnt [2];
  int upd_cyc [2];

  // Frame-level model: bits collected into a number, committed one cycle
  // after the last bit is taken, bank chosen by sel seen with the first bit.
  typedef struct {
    int          nb;
    logic [31:0] acc;
    logic        pend;
    logic        dest;
    logic [31:0] ea;
    logic [31:0] eb;
    logic        ua;
    logic        ub;
  } model_t;

  model_t mst [2];

  function automatic model_t step(model_t m, int w, logic rst, logic v,
                                  logic dn, logic s);
    model_t n = m;
    if (rst) begin
      n.nb = 0; n.acc = '0; n.pend = 1'b0; n.dest = 1'b0;
      n.ea = '0; n.eb = '0; n.ua = 1'b0; n.ub = 1'b0;
      return n;
    end
    n.ua = 1'b0;
    n.ub = 1'b0;
    if (m.pend) begin
      if (m.dest) begin n.ea = m.acc; n.ua = 1'b1; end
      else        begin n.eb = m.acc; n.ub = 1'b1; end
      n.pend = 1'b0;
    end else if (v) begin
      if (m.nb == 0) n.dest = s;
      n.acc = ((m.acc << 1) | 32'(dn)) & ((32'd1 << w) - 32'd1);
      n.nb  = m.nb + 1;
      if (n.nb == w) begin
        n.pend = 1'b1;
        n.nb   = 0;
      end
    end
    return n;
  endfunction

  always @(posedge clk) begin
    for (int d = 0; d < 2; d++)
      mst[d] <= step(mst[d], W[d], reset, in_v[d], in_d[d], in_s[d]);
    cyc <= cyc + 1;
  end

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s at cycle %0d: got %0h, expected %0h", name, cyc, act, exp);
    end
  endtask

  // Per-cycle comparison of both instances against the model.
  always @(negedge clk) begin
    if (chk_en) begin
      for (int d = 0; d < 2; d++) begin
        logic [31:0] aa, ab;
        logic        aua, aub, ardy, abusy;
        string       tag;
        if (d == 0) begin
          aa = 32'(la8); ab = 32'(lb8); aua = ua8; aub = ub8; ardy = rdy8; abusy = busy8;
        end else begin
          aa = 32'(la4); ab = 32'(lb4); aua = ua4; aub = ub4; ardy = rdy4; abusy = busy4;
        end
        tag = $sformatf("w%0d", W[d]);
        chk({tag, ".leds_a"},    aa,           mst[d].ea);
        chk({tag, ".leds_b"},    ab,           mst[d].eb);
        chk({tag, ".upd_a"},     32'(aua),     32'(mst[d].ua));
        chk({tag, ".upd_b"},     32'(aub),     32'(mst[d].ub));
        chk({tag, ".din_ready"}, 32'(ardy),    32'(!mst[d].pend));
        chk({tag, ".busy"},      32'(abusy),   32'(mst[d].pend || mst[d].nb != 0));
        if (aua === 1'b1) begin ua_cnt[d]++; upd_cyc[d] = cyc; end
        if (aub === 1'b1) begin ub_cnt[d]++; upd_cyc[d] = cyc; end
        if (in_v[d] && ardy === 1'b0) low_cnt[d]++;
      end
    end
  end

  task automatic clr_counts();
    for (int d = 0; d < 2; d++) begin
      ua_cnt[d] = 0; ub_cnt[d] = 0; low_cnt[d] = 0;
    end
  endtask

  // Present one bit and hold it until the cycle where it transfers.
  task automatic send_bit(input int d, input logic b, input logic s);
    bit taken = 1'b0;
    in_d[d] = b;
    in_s[d] = s;
    in_v[d] = 1'b1;
    for (int t = 0; t < 40 && !taken; t++) begin
      @(negedge clk);
      taken = !mst[d].pend;
      @(posedge clk);
      #2;
    end
    if (!taken) begin
      fails++;
      $display("FAIL send_bit w%0d: bit never accepted", W[d]);
    end
  endtask

  // Send bits k0..k1-1 of value; returns cycle in which bit 0 was presented.
  task automatic send_frame(input int d, input logic [31:0] value,
                            input int k0, input int k1,
                            input logic s_first, input logic s_rest,
                            output int first_c);
    logic [31:0] v;
    v = value;
    first_c = -1;
    for (int k = k0; k < k1; k++) begin
      send_bit(d, v[W[d] - 1 - k], (k == 0) ? s_first : s_rest);
      if (k == 0) first_c = cyc - 1;
    end
  endtask

  task automatic idle(input int d, input int n);
    in_v[d] = 1'b0;
    repeat (n) begin @(posedge clk); #2; end
  endtask

  initial begin
    int f1, f2, last_c;
    reset = 1'b1;
    for (int d = 0; d < 2; d++) begin
      in_v[d] = 1'b0; in_d[d] = 1'b0; in_s[d] = 1'b0;
    end
    clr_counts();
    repeat (3) begin @(posedge clk); #2; end
    chk_en = 1'b1;

    // Reset state.
    @(negedge clk);
    chk("reset.leds_a", 32'(la8), 32'h0);
    chk("reset.leds_b", 32'(lb8), 32'h0);
    chk("reset.busy",   32'(busy8), 32'h0);
    @(posedge clk); #2;
    reset = 1'b0;
    @(negedge clk);
    chk("post_reset.din_ready", 32'(rdy8), 32'h1);
    @(posedge clk); #2;

    // Frame 8'hAA to bank A, continuous valid.
    clr_counts();
    send_frame(0, 32'hAA, 0, 8, 1'b1, 1'b1, f1);
    last_c = cyc - 1;
    idle(0, 4);
    chk("t1.leds_a", 32'(la8), 32'hAA);
    chk("t1.leds_b", 32'(lb8), 32'h00);
    chk("t1.upd_a_count", 32'(ua_cnt[0]), 32'd1);
    chk("t1.upd_b_count", 32'(ub_cnt[0]), 32'd0);
    chk("t1.upd_latency", 32'(upd_cyc[0] - last_c), 32'd2);

    // sel=0 on first bit, toggled to 1 afterwards: frame goes to B.
    clr_counts();
    send_frame(0, 32'h3C, 0, 8, 1'b0, 1'b1, f1);
    idle(0, 4);
    chk("t2.leds_b", 32'(lb8), 32'h3C);
    chk("t2.leds_a", 32'(la8), 32'hAA);
    chk("t2.upd_a_count", 32'(ua_cnt[0]), 32'd0);
    chk("t2.upd_b_count", 32'(ub_cnt[0]), 32'd1);

    // 8'hF0 with a 5-cycle stall after bit 3.
    clr_counts();
    send_frame(0, 32'hF0, 0, 3, 1'b1, 1'b1, f1);
    in_v[0] = 1'b0;
    repeat (5) begin
      @(negedge clk);
      chk("t3.stall_busy", 32'(busy8), 32'h1);
      @(posedge clk); #2;
    end
    chk("t3.stall_no_upd", 32'(ua_cnt[0] + ub_cnt[0]), 32'd0);
    send_frame(0, 32'hF0, 3, 8, 1'b1, 1'b1, f1);
    idle(0, 4);
    chk("t3.leds_a", 32'(la8), 32'hF0);
    chk("t3.leds_b", 32'(lb8), 32'h3C);

    // Reset after 4 bits, then a clean 8'h81 to bank A.
    clr_counts();
    send_frame(0, 32'hFF, 0, 4, 1'b0, 1'b0, f1);
    in_v[0] = 1'b0;
    reset = 1'b1;
    repeat (2) begin @(posedge clk); #2; end
    chk("t4.reset_leds_a", 32'(la8), 32'h0);
    chk("t4.reset_leds_b", 32'(lb8), 32'h0);
    chk("t4.reset_no_upd", 32'(ua_cnt[0] + ub_cnt[0]), 32'd0);
    reset = 1'b0;
    send_frame(0, 32'h81, 0, 8, 1'b1, 1'b1, f1);
    idle(0, 4);
    chk("t4.leds_a", 32'(la8), 32'h81);
    chk("t4.leds_b", 32'(lb8), 32'h00);
    chk("t4.upd_a_count", 32'(ua_cnt[0]), 32'd1);

    // Back-to-back frames A:8'h55 then B:8'hFF.
    clr_counts();
    send_frame(0, 32'h55, 0, 8, 1'b1, 1'b1, f1);
    send_frame(0, 32'hFF, 0, 8, 1'b0, 1'b0, f2);
    idle(0, 4);
    chk("t5.leds_a", 32'(la8), 32'h55);
    chk("t5.leds_b", 32'(lb8), 32'hFF);
    chk("t5.ready_low_cycles", 32'(low_cnt[0]), 32'd1);
    chk("t5.frame_period", 32'(f2 - f1), 32'd9);
    chk("t5.upd_counts", 32'(ua_cnt[0] * 10 + ub_cnt[0]), 32'd11);

    // WIDTH=4 instance: 4'b1001 to A, then 4'b0110 to B back-to-back.
    clr_counts();
    send_frame(1, 32'h9, 0, 4, 1'b1, 1'b1, f1);
    send_frame(1, 32'h6, 0, 4, 1'b0, 1'b0, f2);
    idle(1, 4);
    chk("t6.leds_a", 32'(la4), 32'h9);
    chk("t6.leds_b", 32'(lb4), 32'h6);
    chk("t6.frame_period", 32'(f2 - f1), 32'd5);
    chk("t6.w8_untouched", 32'(la8), 32'h55);

    chk_en = 1'b0;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, fails);
    $finish;
  end

endmodule
